// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in
// clock cycles and flags a stuck input with a timeout.
// Optional glitch filter: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int unsigned LENGHT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [LENGHT-1:0] high_time,
  output logic [LENGHT-1:0] period,
  output logic              valid,
  output logic              timeout,
  output logic              level
);

  localparam logic [LENGHT-1:0] ONE = LENGHT'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic sync1_q, sync2_q;
  logic s;
  logic lvl;
  logic lvl_dly_q;
  logic [1:0] fill_q;
  logic armed_q;
  logic rise;

  logic [LENGHT-1:0] cnt_p_q, cnt_p_d;
  logic [LENGHT-1:0] cnt_h_q, cnt_h_d;
  logic [LENGHT-1:0] cnt_p_inc;
  logic [LENGHT-1:0] period_q, period_d;
  logic [LENGHT-1:0] high_q, high_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic              level_q, level_d;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  // Tracks when the synchronizer holds real pin samples again after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= {fill_q[0], 1'b1};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Filtered level follows s only once three consecutive samples agree.
  always_comb begin
    lvl = filt_q;
    if ((s == hist_q[0]) && (s == hist_q[1])) begin
      lvl = s;
    end
  end

  // Sample history and held filter output.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], s};
      filt_q <= lvl;
    end
  end
`else
  // Without the filter the synchronized level drives the edge detector.
  always_comb begin
    lvl = s;
  end
`endif

  // Edge detector delay and arming: a rise only counts after the real input
  // has been observed low, so a pin high across reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_dly_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      lvl_dly_q <= lvl;
      armed_q   <= armed_q | (fill_q[1] & ~s & ~lvl);
    end
  end

  assign rise = lvl & ~lvl_dly_q & armed_q;

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_p_q   <= '0;
      cnt_h_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_p_q   <= cnt_p_d;
      cnt_h_q   <= cnt_h_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      level_q   <= level_d;
    end
  end

  // Next-state, counter and measurement logic.
  // Timeout is tested on the incremented count: a period that would reach
  // 2^LENGHT-1 cycles times out, so 2^LENGHT-2 stays the largest measurable.
  always_comb begin
    state_d   = state_q;
    cnt_p_d   = cnt_p_q;
    cnt_h_d   = cnt_h_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    level_d   = level_q;
    cnt_p_inc = cnt_p_q + ONE;

    if (rise) begin
      cnt_p_d = ONE;
      cnt_h_d = ONE;
      case (state_q)
        IDLE:  state_d = RUN;
        RUN: begin
          period_d  = cnt_p_q;
          high_d    = cnt_h_q;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = RUN;
        end
        STALL: state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (state_q != STALL) begin
      cnt_p_d = cnt_p_inc;
      if (lvl) begin
        cnt_h_d = cnt_h_q + ONE;
      end
      if (cnt_p_inc == '1) begin
        period_d  = '0;
        high_d    = '0;
        timeout_d = 1'b1;
        level_d   = lvl;
        valid_d   = 1'b1;
        state_d   = STALL;
      end
    end
  end

  assign high_time = high_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign level     = level_q;

endmodule
